modality_fusion_sync: RTL and testbench
=======================================

# modality_fusion_sync

Synchronizer and scheduler between the per-modality spatial encoders and the temporal encoder. Collects exactly one hypervector per modality for each time step, fuses them by bitwise majority, and forwards the fused vector with mode/label over a valid/ready handshake. It also discards incomplete sets after a configurable timeout, counts the discards and flags mode/label disagreement between modalities.

## Interface
- NUM_MOD, 3, number of modalities; must be odd, ≥1
- TIMEOUT, 64, cycles allowed between first and last capture of a set; 0 disables timeout
- DROP_CNT_WIDTH, 8, width of drop counter
- HV_DIMENSION / LABEL_WIDTH / MODE_WIDTH, from const.vh
- Clk_CI  in  1  clock
- Reset_RI  in  1  reset; one clock, asynchronous, active-high
- ValidIn_SI  in  NUM_MOD  per-modality input valid
- ReadyOut_SO  out  NUM_MOD  per-modality input ready
- ModeIn_SI  in  NUM_MOD*MODE_WIDTH  per-modality mode; modality m at slice m
- LabelIn_DI  in  NUM_MOD*LABEL_WIDTH  per-modality label
- HypervectorIn_DI  in  NUM_MOD*HV_DIMENSION  per-modality spatial HV
- ValidOut_SO  out  1  fused set valid
- ReadyIn_SI  in  1  downstream (temporal encoder) ready
- ModeOut_SO  out  MODE_WIDTH  mode of set (modality 0)
- LabelOut_DO  out  LABEL_WIDTH  label of set (modality 0)
- HypervectorOut_DO  out  HV_DIMENSION  bitwise majority of captured HVs
- DropCnt_SO  out  DROP_CNT_WIDTH  timed-out sets, saturating
- MismatchErr_SO  out  1  sticky: a completed set had mode or label differing from modality 0

## Operation
- States: COLLECT, FORWARD.
- Per modality m: capture register (mode, label, HV) + flag Captured[m].
- COLLECT: ReadyOut_SO[m] = ~Captured[m]. ValidIn_SI[m] & ReadyOut_SO[m] loads register m and sets Captured[m]. Extra valid pulses on already-captured modalities are back-pressured, never overwrite.
- All flags set (counting captures in the current cycle) -> FORWARD next cycle.
- FORWARD: ReadyOut_SO = 0; ValidOut_SO = 1; outputs held stable. ValidOut_SO & ReadyIn_SI -> clear all flags, timeout counter = 0, -> COLLECT.
- Majority: output bit i = 1 iff more than NUM_MOD/2 captured HVs have bit i = 1; NUM_MOD=1 is passthrough.
- Mismatch: on entry to FORWARD, any modality m>0 with mode or label ≠ modality 0 sets MismatchErr_SO. The set is still forwarded. Cleared only by reset.
- Timeout (TIMEOUT>0): the counter counts COLLECT cycles while some but not all flags are set. It starts at 0 on the cycle after the first capture of a set.
  - Counter == TIMEOUT-1 and set not completing this cycle -> clear all flags, counter = 0, DropCnt_SO += 1 (saturate at all-ones), stay COLLECT.
  - A capture arriving on that same cycle is discarded along with the set.
- Completion and timeout in the same cycle: completion wins, no drop.

## Timing
- Reset (async assert, sync-released state): state COLLECT, flags 0, counter 0.
  - Capture registers: 0, with mode = `MODE_PREDICT.
  - Outputs: ReadyOut_SO = all ones, ValidOut_SO = 0, HypervectorOut_DO = 0, LabelOut_DO = 0, ModeOut_SO = `MODE_PREDICT, DropCnt_SO = 0, MismatchErr_SO = 0.
- Latency: ValidOut_SO rises 1 cycle after the last modality's capture edge. With all inputs valid and ReadyIn_SI = 1, one set completes every 2 cycles.
- Outputs are driven from registers and flags only; no combinational path from ValidIn_SI or ReadyIn_SI to outputs, except ReadyOut_SO from state/flags.
- Reset mid-set or mid-FORWARD: set discarded, no drop counted.

## Structure
- const.vh: HV_DIMENSION, LABEL_WIDTH, MODE_WIDTH, MODE_PREDICT/TRAIN/UPDATE, ceilLog2; add FUSION_TIMEOUT default.
- Sub-module hv_majority (combinational, parameters NUM_MOD, HV_DIMENSION): flattened HV bus in, majority HV out.
- Top holds FSM, capture registers, timeout counter, drop counter and error flag.

## Test plan
- Reset, NUM_MOD=3: HVs 0xF0…, 0xCC…, 0xAA… arrive on cycles 2, 5, 3, ReadyIn=1 -> ValidOut_SO at cycle 6, HV = 0xE8…, then COLLECT with all ReadyOut_SO=1.
- Modality 0 pulses valid twice before the others -> second pulse back-pressured (ReadyOut_SO[0]=0), first value forwarded.
- ReadyIn_SI held 0 for 10 cycles in FORWARD -> outputs stable, ReadyOut_SO=0 throughout, single transfer on release.
- TIMEOUT=4: only modality 1 valid -> flags cleared 4 cycles after capture, DropCnt_SO=1, no ValidOut; then a full set forwards normally.
- Labels 3,3,5 -> set forwarded with LabelOut_DO=3, MismatchErr_SO=1 and remains 1 over later clean sets until reset.
- Last capture coincides with timeout cycle -> set forwarded, DropCnt_SO unchanged; async reset asserted in FORWARD -> ValidOut_SO=0 immediately.

Source files
------------

// File: rtl/modality_fusion_sync_pkg.sv
// Shared constants and helpers for the modality fusion synchronizer.
// Holds HV/label/mode widths, mode codes, timeout default and bit helpers.
package modality_fusion_sync_pkg;

  localparam int HV_DIMENSION   = 32;
  localparam int LABEL_WIDTH    = 4;
  localparam int MODE_WIDTH     = 2;
  localparam int FUSION_TIMEOUT = 64;
  localparam int MAX_MOD        = 31;

  localparam logic [MODE_WIDTH-1:0] MODE_TRAIN   = 2'b00;
  localparam logic [MODE_WIDTH-1:0] MODE_PREDICT = 2'b01;
  localparam logic [MODE_WIDTH-1:0] MODE_UPDATE  = 2'b10;

  function automatic int ceilLog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // 1 iff more than num/2 of the first num column bits are set
  function automatic logic majority_bit(
    input logic [MAX_MOD-1:0] col,
    input int                 num
  );
    int ones;
    ones = 0;
    for (int k = 0; k < MAX_MOD; k++)
      if (k < num) ones += int'(col[k]);
    return ones > (num / 2);
  endfunction

endpackage

// File: rtl/modality_fusion_sync_hv_majority.sv
// Bitwise majority across NUM_MOD hypervectors (combinational).
// Ports: HvIn_DI flattened HVs (modality m at slice m), HvOut_DO majority HV.
module hv_majority
  import modality_fusion_sync_pkg::*;
#(
  parameter int NUM_MOD      = 3,
  parameter int HV_DIMENSION = 32
) (
  input  logic [NUM_MOD*HV_DIMENSION-1:0] HvIn_DI,
  output logic [HV_DIMENSION-1:0]         HvOut_DO
);

  logic [MAX_MOD-1:0] col;

  always_comb begin
    HvOut_DO = '0;
    col      = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      col = '0;
      for (int m = 0; m < NUM_MOD; m++)
        col[m] = HvIn_DI[m*HV_DIMENSION+i];
      HvOut_DO[i] = majority_bit(col, NUM_MOD);
    end
  end

endmodule

// File: rtl/modality_fusion_sync.sv
// Collects one HV per modality per time step, fuses by majority and
// forwards over valid/ready; drops stale partial sets, flags mismatches.
// Ports: Clk_CI/Reset_RI, per-modality Valid/Ready/Mode/Label/HV in,
// fused Valid/Ready/Mode/Label/HV out, DropCnt_SO, MismatchErr_SO.
module modality_fusion_sync
  import modality_fusion_sync_pkg::*;
#(
  parameter int NUM_MOD        = 3,
  parameter int TIMEOUT        = FUSION_TIMEOUT,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                            Clk_CI,
  input  logic                            Reset_RI,
  input  logic [NUM_MOD-1:0]              ValidIn_SI,
  output logic [NUM_MOD-1:0]              ReadyOut_SO,
  input  logic [NUM_MOD*MODE_WIDTH-1:0]   ModeIn_SI,
  input  logic [NUM_MOD*LABEL_WIDTH-1:0]  LabelIn_DI,
  input  logic [NUM_MOD*HV_DIMENSION-1:0] HypervectorIn_DI,
  output logic                            ValidOut_SO,
  input  logic                            ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]           ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]          LabelOut_DO,
  output logic [HV_DIMENSION-1:0]         HypervectorOut_DO,
  output logic [DROP_CNT_WIDTH-1:0]       DropCnt_SO,
  output logic                            MismatchErr_SO
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FORWARD = 1'b1;

  localparam int CNT_W = (TIMEOUT > 1) ? ceilLog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam int MW = MODE_WIDTH;
  localparam int LW = LABEL_WIDTH;
  localparam int HW = HV_DIMENSION;

  logic [0:0]                state_q, state_d;
  logic [NUM_MOD-1:0]        capt_q, capt_d;
  logic [NUM_MOD*MW-1:0]     mode_q, mode_d;
  logic [NUM_MOD*LW-1:0]     label_q, label_d;
  logic [NUM_MOD*HW-1:0]     hv_q, hv_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      err_q, err_d;

  logic [NUM_MOD-1:0] fire;
  logic               collect;
  logic               complete;
  logic               tmo_hit;
  logic               mism;

  assign collect     = (state_q == ST_COLLECT);
  assign ReadyOut_SO = collect ? ~capt_q : '0;
  assign fire        = ValidIn_SI & ReadyOut_SO;
  assign complete    = collect && (&(capt_q | fire));

  // Completion outranks timeout on the same cycle
  assign tmo_hit = (TIMEOUT > 0) && collect && (|capt_q)
                 && (cnt_q == TMO_LAST) && !complete;

  always_comb begin
    mode_d  = mode_q;
    label_d = label_q;
    hv_d    = hv_q;
    for (int m = 0; m < NUM_MOD; m++) begin
      if (fire[m]) begin
        mode_d[m*MW +: MW]  = ModeIn_SI[m*MW +: MW];
        label_d[m*LW +: LW] = LabelIn_DI[m*LW +: LW];
        hv_d[m*HW +: HW]    = HypervectorIn_DI[m*HW +: HW];
      end
    end
  end

  // Compare against next-state regs so same-cycle captures count
  always_comb begin
    mism = 1'b0;
    for (int m = 1; m < NUM_MOD; m++) begin
      if (mode_d[m*MW +: MW] != mode_d[MW-1:0] ||
          label_d[m*LW +: LW] != label_d[LW-1:0])
        mism = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    capt_d  = capt_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    err_d   = err_q;
    if (collect) begin
      if (complete) begin
        state_d = ST_FORWARD;
        capt_d  = capt_q | fire;
        cnt_d   = '0;
        err_d   = err_q | mism;
      end else if (tmo_hit) begin
        capt_d = '0;
        cnt_d  = '0;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end else begin
        capt_d = capt_q | fire;
        cnt_d  = (|capt_q) ? cnt_q + 1'b1 : '0;
      end
    end else if (ReadyIn_SI) begin
      state_d = ST_COLLECT;
      capt_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= ST_COLLECT;
      capt_q  <= '0;
      mode_q  <= {NUM_MOD{MODE_PREDICT}};
      label_q <= '0;
      hv_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      capt_q  <= capt_d;
      mode_q  <= mode_d;
      label_q <= label_d;
      hv_q    <= hv_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  hv_majority #(
    .NUM_MOD      (NUM_MOD),
    .HV_DIMENSION (HV_DIMENSION)
  ) u_maj (
    .HvIn_DI  (hv_q),
    .HvOut_DO (HypervectorOut_DO)
  );

  assign ValidOut_SO    = (state_q == ST_FORWARD);
  assign ModeOut_SO     = mode_q[MW-1:0];
  assign LabelOut_DO    = label_q[LW-1:0];
  assign DropCnt_SO     = drop_q;
  assign MismatchErr_SO = err_q;

endmodule

// File: tb/tb_modality_fusion_sync.sv
// Scoreboard bench for modality_fusion_sync (NUM_MOD=3, TIMEOUT=4).
// Stimulus pushes expected sets; a negedge monitor pops on handshake.
module tb_modality_fusion_sync;
  import modality_fusion_sync_pkg::*;

  typedef struct packed {
    logic [31:0] hv;
    logic [3:0]  lbl;
    logic [1:0]  mode;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vin = '0;
  logic [2:0]  rdy_o;
  logic [5:0]  mode_bus;
  logic [11:0] lbl_bus;
  logic [95:0] hv_bus;
  logic        vout;
  logic        rdy_i = 1'b1;
  logic [1:0]  mode_o;
  logic [3:0]  lbl_o;
  logic [31:0] hv_o;
  logic [7:0]  drop_o;
  logic        err_o;

  logic [31:0] hv_in   [3];
  logic [3:0]  lbl_in  [3];
  logic [1:0]  mode_in [3];

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int m = 0; m < 3; m++) begin
      hv_bus[m*32 +: 32]  = hv_in[m];
      lbl_bus[m*4 +: 4]   = lbl_in[m];
      mode_bus[m*2 +: 2]  = mode_in[m];
    end
  end

  modality_fusion_sync #(
    .NUM_MOD        (3),
    .TIMEOUT        (4),
    .DROP_CNT_WIDTH (8)
  ) dut (
    .Clk_CI            (clk),
    .Reset_RI          (rst),
    .ValidIn_SI        (vin),
    .ReadyOut_SO       (rdy_o),
    .ModeIn_SI         (mode_bus),
    .LabelIn_DI        (lbl_bus),
    .HypervectorIn_DI  (hv_bus),
    .ValidOut_SO       (vout),
    .ReadyIn_SI        (rdy_i),
    .ModeOut_SO        (mode_o),
    .LabelOut_DO       (lbl_o),
    .HypervectorOut_DO (hv_o),
    .DropCnt_SO        (drop_o),
    .MismatchErr_SO    (err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic set_m(input int m, input logic [31:0] hv,
                       input logic [3:0] lb, input logic [1:0] md);
    hv_in[m]   = hv;
    lbl_in[m]  = lb;
    mode_in[m] = md;
  endtask

  task automatic set_all(input logic [31:0] h0, input logic [31:0] h1,
                         input logic [31:0] h2, input logic [3:0] lb,
                         input logic [1:0] md);
    set_m(0, h0, lb, md);
    set_m(1, h1, lb, md);
    set_m(2, h2, lb, md);
  endtask

  task automatic cyc(input logic [2:0] v);
    vin = v;
    @(posedge clk);
    #1;
    vin = '0;
  endtask

  task automatic push(input logic [31:0] hv, input logic [3:0] lb,
                      input logic [1:0] md);
    exp_t e;
    e.hv   = hv;
    e.lbl  = lb;
    e.mode = md;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && vout && rdy_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got hv 0x%0h expected none", hv_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_hv", hv_o, e.hv);
        chk("out_label", 32'(lbl_o), 32'(e.lbl));
        chk("out_mode", 32'(mode_o), 32'(e.mode));
      end
    end
  end

  initial begin
    for (int m = 0; m < 3; m++) set_m(m, '0, '0, MODE_TRAIN);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy_o), 32'h7);
    chk("rst_valid", 32'(vout), 32'h0);
    chk("rst_hv", hv_o, 32'h0);
    chk("rst_label", 32'(lbl_o), 32'h0);
    chk("rst_mode", 32'(mode_o), 32'(MODE_PREDICT));
    chk("rst_drop", 32'(drop_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;

    // staggered arrivals: m0, m2, gap, m1
    set_all(32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA, 4'd6, MODE_TRAIN);
    push(32'hE8E8E8E8, 4'd6, MODE_TRAIN);
    cyc(3'b000);
    cyc(3'b001);
    cyc(3'b100);
    cyc(3'b000);
    chk("t1_not_yet", 32'(vout), 32'h0);
    cyc(3'b010);
    chk("t1_valid", 32'(vout), 32'h1);
    chk("t1_rdy_fwd", 32'(rdy_o), 32'h0);
    cyc(3'b000);
    chk("t1_back_valid", 32'(vout), 32'h0);
    chk("t1_back_rdy", 32'(rdy_o), 32'h7);

    // m0 pulses twice; second must be back-pressured
    set_all(32'h0000FFFF, 32'h00FF00FF, 32'h0F0F0F0F, 4'd1, MODE_TRAIN);
    cyc(3'b001);
    chk("t2_bp_rdy0", 32'(rdy_o), 32'h6);
    set_m(0, 32'hFFFF0000, 4'd9, MODE_UPDATE);
    cyc(3'b001);
    push(32'h000F0FFF, 4'd1, MODE_TRAIN);
    cyc(3'b110);
    chk("t2_valid", 32'(vout), 32'h1);
    cyc(3'b000);

    // downstream stall for 10 cycles
    rdy_i = 1'b0;
    set_all(32'h12345678, 32'h12345678, 32'hFFFFFFFF, 4'd7, MODE_UPDATE);
    cyc(3'b111);
    set_all(32'h0, 32'h0, 32'h0, 4'd0, MODE_TRAIN);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(vout), 32'h1);
      chk("t3_hold_rdy", 32'(rdy_o), 32'h0);
      chk("t3_hold_hv", hv_o, 32'h12345678);
      cyc(3'b111);
    end
    push(32'h12345678, 4'd7, MODE_UPDATE);
    rdy_i = 1'b1;
    cyc(3'b000);
    chk("t3_released", 32'(vout), 32'h0);

    // timeout on lone modality 1
    set_m(1, 32'h1, 4'd1, MODE_TRAIN);
    cyc(3'b010);
    chk("t4_part_rdy", 32'(rdy_o), 32'h5);
    repeat (3) cyc(3'b000);
    chk("t4_pre_rdy", 32'(rdy_o), 32'h5);
    chk("t4_pre_drop", 32'(drop_o), 32'h0);
    cyc(3'b000);
    chk("t4_tmo_rdy", 32'(rdy_o), 32'h7);
    chk("t4_tmo_drop", 32'(drop_o), 32'h1);
    chk("t4_tmo_valid", 32'(vout), 32'h0);
    // capture landing on the timeout cycle is discarded
    cyc(3'b001);
    repeat (3) cyc(3'b000);
    cyc(3'b010);
    chk("t4b_rdy", 32'(rdy_o), 32'h7);
    chk("t4b_drop", 32'(drop_o), 32'h2);
    chk("t4b_valid", 32'(vout), 32'h0);
    set_all(32'h11111111, 32'h22222222, 32'h33333333, 4'd2, MODE_PREDICT);
    push(32'h33333333, 4'd2, MODE_PREDICT);
    cyc(3'b111);
    chk("t4c_valid", 32'(vout), 32'h1);
    cyc(3'b000);

    // label mismatch is sticky
    chk("t5_err_pre", 32'(err_o), 32'h0);
    set_all(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd3, MODE_TRAIN);
    set_m(2, 32'hA5A5A5A5, 4'd5, MODE_TRAIN);
    push(32'hA5A5A5A5, 4'd3, MODE_TRAIN);
    cyc(3'b111);
    cyc(3'b000);
    chk("t5_err_set", 32'(err_o), 32'h1);
    set_all(32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 4'd4, MODE_UPDATE);
    push(32'hDEADBEEF, 4'd4, MODE_UPDATE);
    cyc(3'b111);
    cyc(3'b000);
    chk("t5_err_sticky", 32'(err_o), 32'h1);

    // completion on the timeout cycle wins
    set_all(32'h80000001, 32'h80000000, 32'h00000001, 4'd9, MODE_TRAIN);
    cyc(3'b001);
    repeat (3) cyc(3'b000);
    push(32'h80000001, 4'd9, MODE_TRAIN);
    cyc(3'b110);
    chk("t6_valid", 32'(vout), 32'h1);
    chk("t6_drop", 32'(drop_o), 32'h2);
    cyc(3'b000);
    chk("t6_rdy", 32'(rdy_o), 32'h7);

    // async reset while in FORWARD
    rdy_i = 1'b0;
    set_all(32'h55555555, 32'h55555555, 32'h55555555, 4'd1, MODE_TRAIN);
    cyc(3'b111);
    chk("t7_valid", 32'(vout), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_valid", 32'(vout), 32'h0);
    chk("t7_rst_rdy", 32'(rdy_o), 32'h7);
    chk("t7_rst_hv", hv_o, 32'h0);
    chk("t7_rst_drop", 32'(drop_o), 32'h0);
    chk("t7_rst_err", 32'(err_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_i = 1'b1;
    repeat (3) cyc(3'b000);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
